// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and immediate-format modes for the MIPS datapath
package mips_pkg;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        EXT_SEXT = 2'b00,
        EXT_ZEXT = 2'b01,
        EXT_LUI  = 2'b10,
        EXT_BOFS = 2'b11
    } ext_mode_e;

endpackage

// File: rtl/mips_sign_extension.sv
// rtl/mips_sign_extension.sv - immediate extension: combinational sign extend plus registered formatter
module mips_sign_extension
    import mips_pkg::*;
#(
    parameter int IN_W  = IMM_W,
    parameter int OUT_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  i,
    output logic [OUT_W-1:0] o,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic [OUT_W-1:0] o_q,
    output logic             out_valid
);

    function automatic logic [OUT_W-1:0] format_imm(input logic [1:0] m, input logic [IN_W-1:0] imm);
        logic [OUT_W-1:0] sext;
        logic [OUT_W-1:0] res;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (m)
            EXT_SEXT: res = sext;
            EXT_ZEXT: res = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_LUI:  res = {imm, {(OUT_W-IN_W){1'b0}}};
            // Branch offset: word-aligned, sign bits already fill the top.
            EXT_BOFS: res = {sext[OUT_W-3:0], 2'b00};
            default:  res = sext;
        endcase
        return res;
    endfunction

    assign o = {{(OUT_W-IN_W){i[IN_W-1]}}, i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                o_q <= format_imm(mode, i);
            end
        end
    end

endmodule

// File: tb/tb_mips_sign_extension.sv
// tb/tb_mips_sign_extension.sv - directed self-checking bench for mips_sign_extension
module tb_mips_sign_extension;

    logic        clk;
    logic        rst;
    logic [15:0] i;
    logic [31:0] o;
    logic [1:0]  mode;
    logic        in_valid;
    logic [31:0] o_q;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    mips_sign_extension dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .o         (o),
        .mode      (mode),
        .in_valid  (in_valid),
        .o_q       (o_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; i = 16'h1234; mode = 2'b00; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_q !== 32'h0) begin
            errors++; $display("FAIL reset_o_q: got %h expected %h", o_q, 32'h0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected %b", out_valid, 1'b0);
        end
        checks++;
        if (o !== 32'h00001234) begin
            errors++; $display("FAIL reset_comb_o: got %h expected %h", o, 32'h00001234);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_comb_vectors();
        logic [15:0] vin [7];
        logic [31:0] vexp [7];
        vin[0] = 16'h0000; vexp[0] = 32'h00000000;
        vin[1] = 16'hffff; vexp[1] = 32'hffffffff;
        vin[2] = 16'hfffe; vexp[2] = 32'hfffffffe;
        vin[3] = 16'h7fff; vexp[3] = 32'h00007fff;
        vin[4] = 16'h0001; vexp[4] = 32'h00000001;
        vin[5] = 16'h8000; vexp[5] = 32'hffff8000;
        vin[6] = 16'h5a5a; vexp[6] = 32'h00005a5a;
        for (int k = 0; k < 7; k++) begin
            i = vin[k];
            #1;
            checks++;
            if (o !== vexp[k]) begin
                errors++; $display("FAIL comb_vec[%0d]: i=%h got %h expected %h", k, vin[k], o, vexp[k]);
            end
        end
    endtask

    task automatic test_comb_stable();
        i = 16'h8000; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (o !== 32'hffff8000) begin
                errors++; $display("FAIL comb_stable[%0d]: got %h expected %h", k, o, 32'hffff8000);
            end
        end
    endtask

    task automatic test_modes();
        logic [31:0] mexp [4];
        mexp[0] = 32'hffff8000;
        mexp[1] = 32'h00008000;
        mexp[2] = 32'h80000000;
        mexp[3] = 32'hfffe0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i = 16'h8000; mode = 2'(k); in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (o_q !== mexp[k]) begin
                errors++; $display("FAIL mode_%0d_o_q: got %h expected %h", k, o_q, mexp[k]);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL mode_%0d_out_valid: got %b expected %b", k, out_valid, 1'b1);
            end
        end
        // Other immediates through each format
        @(negedge clk);
        i = 16'h1234; mode = 2'b10; in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o_q !== 32'h12340000) begin
            errors++; $display("FAIL lui_1234: got %h expected %h", o_q, 32'h12340000);
        end
        @(negedge clk);
        i = 16'hffff; mode = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (o_q !== 32'h0000ffff) begin
            errors++; $display("FAIL zext_ffff: got %h expected %h", o_q, 32'h0000ffff);
        end
        @(negedge clk);
        i = 16'h7fff; mode = 2'b11;
        @(posedge clk); #1;
        checks++;
        if (o_q !== 32'h0001fffc) begin
            errors++; $display("FAIL bofs_7fff: got %h expected %h", o_q, 32'h0001fffc);
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        i = 16'h8000; mode = 2'b11; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; mode = 2'bxx; i = 16'h0042;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (o_q !== 32'hfffe0000) begin
            errors++; $display("FAIL hold_o_q: got %h expected %h", o_q, 32'hfffe0000);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_out_valid: got %b expected %b", out_valid, 1'b0);
        end
        mode = 2'b00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        i = 16'hfffe; mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (o_q !== 32'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got o_q=%h out_valid=%b expected o_q=%h out_valid=%b", o_q, out_valid, 32'h0, 1'b0);
        end
        checks++;
        if (o !== 32'hfffffffe) begin
            errors++; $display("FAIL reset_mid_comb_o: got %h expected %h", o, 32'hfffffffe);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o_q !== 32'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_held: got o_q=%h out_valid=%b expected o_q=%h out_valid=%b", o_q, out_valid, 32'h0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0; i = 16'h0001; mode = 2'b11; in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (o_q !== 32'h00000004 || out_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset_capture: got o_q=%h out_valid=%b expected o_q=%h out_valid=%b", o_q, out_valid, 32'h4, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_sweep();
        logic signed [31:0] exp_v;
        int sweep_err;
        sweep_err = 0;
        for (int k = 0; k < 65536; k++) begin
            i = 16'(k);
            exp_v = $signed(16'(k));
            #1;
            checks++;
            if (o !== exp_v) begin
                errors++;
                sweep_err++;
                if (sweep_err <= 10)
                    $display("FAIL sweep: i=%h got %h expected %h", i, o, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_comb_vectors();
        test_comb_stable();
        test_modes();
        test_hold();
        test_reset_mid();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
